uart_tx_serializer: RTL and testbench

//  UART transmit serializer; directly downstream of the TX-side system controller.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_cnt.sv | 48 ++++
 rtl/uart_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types, parity encodings and the parity helper for the
//             UART transmit serializer.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmit frame phases, in the order they occur on the line
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity over a zero-extended word; zero padding leaves the XOR unchanged
  function automatic logic calc_parity(input logic [63:0] data, input logic typ);
    return (typ == PAR_EVEN) ? (^data) : (~^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_cnt
//  Brief    : Baud divider. Counts 0..CLKS_PER_BIT-1 while run is high and
//             pulses bit_done on the last cycle of every bit period. With
//             CLKS_PER_BIT==1 the count stays at zero and bit_done follows run.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done = run && (cnt_q == CNT_LAST);

  // Next count: hold at zero while idle, wrap at the end of each bit
  always_comb begin
    cnt_d = cnt_q;
    if (!run || bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer
//  Brief    : UART transmit serializer. Accepts one WIDTH-bit word per
//             valid/busy handshake and sends start, data (LSB first),
//             optional parity and stop bit(s). tx_out and busy_out are flops.
//  Config   : UART_TX_STOP2_EN defined -> two stop bits, otherwise one.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid_in,
  input  logic             par_en_in,
  input  logic             par_typ_in,
  output logic             tx_out,
  output logic             busy_out
);

  // Bit index also counts stop bits, so it needs at least one bit
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             par_en_q, par_en_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             bit_done;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q != IDLE),
    .bit_done (bit_done)
  );

  // Next state and next line level; tx_d is what the line shows next cycle
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_valid_in) begin
          state_d  = START;
          shift_d  = data_in;
          par_en_d = par_en_in;
          par_d    = calc_parity(64'(data_in), par_typ_in);
          idx_d    = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
`ifdef UART_TX_STOP2_EN
          if (idx_q == '0) begin
            idx_d = IDX_W'(1);
          end else begin
            idx_d   = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_out   = tx_q;
  assign busy_out = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_serializer
//  Brief    : Bench for uart_tx_serializer. Two instances (CLKS_PER_BIT 4
//             and 1) are compared every cycle against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int W = 8;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP      = 2;
  localparam int LEN4_NOPAR = 44;
  localparam int LEN4_PAR   = 48;
  localparam int LEN1_NOPAR = 11;
`else
  localparam int NSTOP      = 1;
  localparam int LEN4_NOPAR = 40;
  localparam int LEN4_PAR   = 44;
  localparam int LEN1_NOPAR = 10;
`endif

  function automatic int cpb_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  logic         clk = 1'b0;
  logic [1:0]   rst;
  logic [1:0]   vld;
  logic [1:0]   pen;
  logic [1:0]   ptyp;
  logic [W-1:0] din [2];
  wire  [1:0]   tx;
  wire  [1:0]   busy;

  always #5 clk = ~clk;

  uart_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(rst[0]), .data_in(din[0]), .data_valid_in(vld[0]),
    .par_en_in(pen[0]), .par_typ_in(ptyp[0]), .tx_out(tx[0]), .busy_out(busy[0])
  );

  uart_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(rst[1]), .data_in(din[1]), .data_valid_in(vld[1]),
    .par_en_in(pen[1]), .par_typ_in(ptyp[1]), .tx_out(tx[1]), .busy_out(busy[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Frame-level model: a list of line bits and a cycle position within it
  bit          m_act  [2];
  int          m_pos  [2];
  int          m_nb   [2];
  logic [11:0] m_bits [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_act[d] = 1'b0;
      end else if (m_act[d]) begin
        m_pos[d] = m_pos[d] + 1;
        if (m_pos[d] == m_nb[d] * cpb_of(d)) m_act[d] = 1'b0;
      end else if (vld[d]) begin
        m_bits[d]    = '1;
        m_bits[d][0] = 1'b0;
        for (int i = 0; i < W; i++) m_bits[d][1+i] = din[d][i];
        m_nb[d] = 1 + W + NSTOP;
        if (pen[d]) begin
          m_bits[d][1+W] = ptyp[d] ? ~^din[d] : ^din[d];
          m_nb[d] = m_nb[d] + 1;
        end
        m_pos[d] = 0;
        m_act[d] = 1'b1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic eb, et;
        eb = m_act[d];
        et = m_act[d] ? m_bits[d][m_pos[d] / cpb_of(d)] : 1'b1;
        checks = checks + 1;
        if (busy[d] !== eb) begin
          errors = errors + 1;
          $display("FAIL model_busy dut%0d t=%0t got %b exp %b", d, $time, busy[d], eb);
        end
        checks = checks + 1;
        if (tx[d] !== et) begin
          errors = errors + 1;
          $display("FAIL model_tx dut%0d t=%0t got %b exp %b", d, $time, tx[d], et);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  logic capq [0:127];

  // Send one word on instance d (called at a negedge). Valid is held for
  // 'hold' busy cycles; inputs are scrambled once valid drops.
  task automatic send(input int d, input logic [7:0] data, input logic pe,
                      input logic pt, input int hold, output int wait_n, output int len);
    din[d] = data; pen[d] = pe; ptyp[d] = pt; vld[d] = 1'b1;
    wait_n = 0;
    len    = 0;
    while (busy[d] !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n = wait_n + 1;
    end
    if (busy[d] !== 1'b1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout dut%0d got busy=%b exp 1", d, busy[d]);
      vld[d] = 1'b0;
      return;
    end
    while (busy[d] === 1'b1 && len < 120) begin
      capq[len] = tx[d];
      if (len >= hold) begin
        vld[d] = 1'b0;
        din[d] = 8'($urandom);
        pen[d] = 1'($urandom);
        ptyp[d] = 1'($urandom);
      end
      len = len + 1;
      @(negedge clk);
    end
    if (len >= 120) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL frame_timeout dut%0d got len>=%0d exp busy drop", d, len);
    end
    vld[d] = 1'b0;
    check("idle_tx_after_frame", int'(tx[d]), 1);
  endtask

  function automatic logic [9:0] sample10(input int cpb);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = capq[i * cpb + cpb / 2];
    return v;
  endfunction

  initial begin
    int w, l;
    logic [9:0] v;
    rst = 2'b11; vld = 2'b00; pen = 2'b00; ptyp = 2'b00;
    din[0] = '0; din[1] = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_tx", int'(tx), 3);
    check("reset_busy", int'(busy), 0);
    rst = 2'b00;
    repeat (2) @(negedge clk);

    // 0xA5 without parity
    send(0, 8'hA5, 1'b0, 1'b0, 0, w, l);
    check("a5_len", l, LEN4_NOPAR);
    check("a5_bits", int'(sample10(4)), int'(10'b1101001010));
    repeat (2) @(negedge clk);

    // 0xA5 even then odd parity
    send(0, 8'hA5, 1'b1, 1'b0, 0, w, l);
    check("even_len", l, LEN4_PAR);
    check("even_par_bit", int'(capq[9*4+2]), 0);
    @(negedge clk);
    send(0, 8'hA5, 1'b1, 1'b1, 0, w, l);
    check("odd_len", l, LEN4_PAR);
    check("odd_par_bit", int'(capq[9*4+2]), 1);
    @(negedge clk);

    // Valid held three cycles into busy: single frame only
    send(0, 8'h5A, 1'b0, 1'b0, 3, w, l);
    check("hold_len", l, LEN4_NOPAR);
    repeat (8) @(negedge clk);
    check("hold_no_restart", int'(busy[0]), 0);

    // Two-byte result, low byte first, second valid in the idle cycle
    send(0, 8'h34, 1'b0, 1'b0, 0, w, l);
    v = sample10(4);
    check("lo_byte", int'(v[8:1]), 'h34);
    send(0, 8'h12, 1'b0, 1'b0, 0, w, l);
    check("b2b_gap", w, 1);
    check("hi_len", l, LEN4_NOPAR);
    v = sample10(4);
    check("hi_byte", int'(v[8:1]), 'h12);
    repeat (2) @(negedge clk);

    // Reset at cycle 10 of a frame
    din[0] = 8'hC3; vld[0] = 1'b1;
    w = 0;
    while (busy[0] !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("rst_frame_started", int'(busy[0]), 1);
    vld[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_tx", int'(tx[0]), 1);
    check("abort_busy", int'(busy[0]), 0);
    rst[0] = 1'b0;
    @(negedge clk);
    send(0, 8'h3C, 1'b0, 1'b0, 0, w, l);
    check("post_rst_len", l, LEN4_NOPAR);

    // One clock per bit
    send(1, 8'hFF, 1'b0, 1'b0, 0, w, l);
    check("cpb1_len", l, LEN1_NOPAR);
    check("cpb1_bits", int'(sample10(1)), int'(10'b1111111110));
    if (NSTOP == 2) check("cpb1_stop2", int'(capq[10]), 1);
    @(negedge clk);

    // Randomized frames on both instances
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        send(d, 8'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), w, l);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
